// File: rtl/elementwise_stream_multiplier.sv
// Serial element-wise multiplier: loads LEN operand pairs, multiplies each on
// acceptance into a product buffer, then streams the LEN products back out in index order.
module elementwise_stream_multiplier #(
   parameter int WIDTH = 8,
   parameter int LEN   = 8,
   parameter int IDXW  = $clog2(LEN)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_data,
   output logic [IDXW-1:0]      out_index,
   output logic                 out_last,
   output logic                 busy
);

   localparam logic ST_LOAD  = 1'b0;
   localparam logic ST_DRAIN = 1'b1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LEN - 1);

   logic                 state;
   logic [IDXW-1:0]      wr_idx;
   logic [IDXW-1:0]      rd_idx;
   logic [2*WIDTH-1:0]   prod_mem [LEN];
   logic [2*WIDTH-1:0]   product;
   logic                 in_fire;
   logic                 out_fire;

   // Zero-extend both operands so the multiply is unsigned and full width.
   assign product  = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_LOAD;
         wr_idx <= '0;
         rd_idx <= '0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (in_fire) begin
                  if (wr_idx == LAST_IDX) begin
                     wr_idx <= '0;
                     state  <= ST_DRAIN;
                  end else begin
                     wr_idx <= wr_idx + 1'b1;
                  end
               end
            end
            default: begin
               if (out_fire) begin
                  if (rd_idx == LAST_IDX) begin
                     rd_idx <= '0;
                     state  <= ST_LOAD;
                  end else begin
                     rd_idx <= rd_idx + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // NOTE: the product buffer is deliberately not reset; every slot is written
   // before it is read, and out_data is forced to zero outside DRAIN instead.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         prod_mem[wr_idx] <= product;
      end
   end

   // Handshake outputs decode only registered state.
   assign in_ready  = (state == ST_LOAD);
   assign out_valid = (state == ST_DRAIN);
   assign out_data  = out_valid ? prod_mem[rd_idx] : '0;
   assign out_index = rd_idx;
   assign out_last  = out_valid && (rd_idx == LAST_IDX);
   assign busy      = out_valid || (wr_idx != '0);

endmodule

// File: tb/tb_elementwise_stream_multiplier.sv
// Directed bench: table of operand vectors with hand-computed products, plus
// hand-written reset-during-load and reset-during-drain sequences.
module tb_elementwise_stream_multiplier;

   localparam int WIDTH = 8;
   localparam int LEN   = 8;
   localparam int IDXW  = 3;

   logic                 clk;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_a;
   logic [WIDTH-1:0]     in_b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out_data;
   logic [IDXW-1:0]      out_index;
   logic                 out_last;
   logic                 busy;

   int pass_cnt  = 0;
   int check_cnt = 0;

   typedef struct {
      logic [WIDTH-1:0]   a   [LEN];
      logic [WIDTH-1:0]   b   [LEN];
      logic [2*WIDTH-1:0] exp [LEN];
      int                 gap;
      logic [3:0]         rdy;
      bit                 junk;
   } vec_t;

   vec_t tbl [6];

   elementwise_stream_multiplier #(.WIDTH(WIDTH), .LEN(LEN), .IDXW(IDXW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Called at a negedge with the DUT in LOAD; returns at a negedge back in LOAD.
   task automatic run_vector(input int v);
      int idx;
      int cyc;
      for (int i = 0; i < LEN; i++) begin
         for (int g = 0; g < tbl[v].gap; g++) begin
            in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("gap_busy", busy, (i != 0));
            check("gap_in_ready", in_ready, 1);
         end
         in_valid = 1'b1;
         in_a     = tbl[v].a[i];
         in_b     = tbl[v].b[i];
         check("load_in_ready", in_ready, 1);
         check("load_out_valid", out_valid, 0);
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = tbl[v].junk;
      in_a     = 8'd99;
      in_b     = 8'd99;
      check("first_out_valid", out_valid, 1);
      check("drain_busy", busy, 1);
      idx = 0;
      cyc = 0;
      while (idx < LEN && cyc < 64) begin
         out_ready = tbl[v].rdy[cyc % 4];
         check("drain_out_valid", out_valid, 1);
         check("drain_in_ready", in_ready, 0);
         check("out_data", out_data, tbl[v].exp[idx]);
         check("out_index", out_index, idx);
         check("out_last", out_last, (idx == LEN - 1));
         @(posedge clk);
         if (out_ready) idx++;
         cyc++;
         @(negedge clk);
      end
      check("drain_complete", idx, LEN);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("post_in_ready", in_ready, 1);
      check("post_out_valid", out_valid, 0);
      check("post_busy", busy, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_out_index"}, out_index, 0);
      check({tag, "_out_last"}, out_last, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      // Nominal: a = 1..8, b = 8..1.
      tbl[0].a   = '{1, 2, 3, 4, 5, 6, 7, 8};
      tbl[0].b   = '{8, 7, 6, 5, 4, 3, 2, 1};
      tbl[0].exp = '{8, 14, 18, 20, 20, 18, 14, 8};
      tbl[0].gap = 0; tbl[0].rdy = 4'b1111; tbl[0].junk = 1'b0;
      // Maximum operands.
      tbl[1].a   = '{255, 255, 255, 255, 255, 255, 255, 255};
      tbl[1].b   = '{255, 255, 255, 255, 255, 255, 255, 255};
      tbl[1].exp = '{16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01,
                     16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01};
      tbl[1].gap = 0; tbl[1].rdy = 4'b1111; tbl[1].junk = 1'b0;
      // Backpressure: out_ready 1,0,0,1 repeating (bit 0 first).
      tbl[2].a   = '{1, 2, 3, 4, 5, 6, 7, 8};
      tbl[2].b   = '{2, 2, 2, 2, 2, 2, 2, 2};
      tbl[2].exp = '{2, 4, 6, 8, 10, 12, 14, 16};
      tbl[2].gap = 0; tbl[2].rdy = 4'b1001; tbl[2].junk = 1'b0;
      // Gapped input, 99*99 offered throughout DRAIN.
      tbl[3].a   = '{3, 3, 3, 3, 3, 3, 3, 3};
      tbl[3].b   = '{1, 2, 3, 4, 5, 6, 7, 8};
      tbl[3].exp = '{3, 6, 9, 12, 15, 18, 21, 24};
      tbl[3].gap = 2; tbl[3].rdy = 4'b1111; tbl[3].junk = 1'b1;
      // Back-to-back follow-up with a zero product and mixed values.
      tbl[4].a   = '{0, 1, 2, 3, 16, 100, 200, 255};
      tbl[4].b   = '{5, 5, 5, 5, 16, 10, 2, 1};
      tbl[4].exp = '{0, 5, 10, 15, 256, 1000, 400, 255};
      tbl[4].gap = 0; tbl[4].rdy = 4'b1011; tbl[4].junk = 1'b1;
      // Reload after reset: 2*3 everywhere.
      tbl[5].a   = '{2, 2, 2, 2, 2, 2, 2, 2};
      tbl[5].b   = '{3, 3, 3, 3, 3, 3, 3, 3};
      tbl[5].exp = '{6, 6, 6, 6, 6, 6, 6, 6};
      tbl[5].gap = 0; tbl[5].rdy = 4'b1111; tbl[5].junk = 1'b0;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("idle");

      // Vectors 0..4 run with no idle cycles between them.
      for (int v = 0; v < 5; v++) run_vector(v);

      // Reset after 5 of 8 pairs are loaded.
      in_valid = 1'b1;
      in_a     = 8'd9;
      in_b     = 8'd9;
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("partial_busy", busy, 1);
      check("partial_out_valid", out_valid, 0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_load");
      @(negedge clk);
      rst_n = 1'b1;
      run_vector(5);

      // Reset in the middle of DRAIN.
      in_valid = 1'b1;
      in_a     = 8'd4;
      in_b     = 8'd4;
      repeat (LEN) begin
         @(posedge clk);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("mid_drain_data0", out_data, 16);
      @(posedge clk);
      @(negedge clk);
      check("mid_drain_index1", out_index, 1);
      out_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_drain");
      @(negedge clk);
      rst_n = 1'b1;
      run_vector(0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
